frame_binarizer_capture: RTL
============================

// Module: frame_binarizer_capture
// PURPOSE
//  Upstream stage of horizontal finder scan: crops a WIDTH x HEIGHT window from camera luma stream,
//  thresholds each pixel to 1 bit (1 = white, 0 = black), writes it row-major into the 1-bit frame BRAM
//  at addr = x + y*WIDTH. Captures one frame per request, then freezes BRAM contents for the finder.
// PARAMETERS
//  WIDTH     480  window width, pixels
//  HEIGHT    480  window height, pixels
//  X_OFFSET  400  camera hcount of window column 0
//  Y_OFFSET  120  camera vcount of window row 0
// PORTS
//  clk_in          in   1   system clock
//  rst_in          in   1   synchronous, active-high reset
//  pixel_valid_in  in   1   camera pixel strobe
//  hcount_in       in   11  camera column of current pixel
//  vcount_in       in   10  camera row of current pixel
//  luma_in         in   8   pixel luminance
//  threshold_in    in   8   fixed threshold, sampled at arm
//  capture_req_in  in   1   one-cycle request to capture next full frame
//  bram_addr_out   out  20  write address
//  bram_din_out    out  1   binarized pixel
//  bram_we_out     out  1   write enable
//  busy_out        out  1   high in ARMED or CAPTURE
//  frame_done_out  out  1   one-cycle pulse, full window written
//  threshold_out   out  8   threshold applied to current/last capture
// BEHAVIOUR
//  Reset: state IDLE; all outputs 0 except threshold_out = threshold_in sampled on reset cycle.
//  FSM: IDLE -capture_req-> ARMED (latch threshold) -SOF-> CAPTURE -last write-> DONE -> IDLE (1 cycle).
//   SOF = pixel_valid_in && hcount_in==0 && vcount_in==0.
//   capture_req_in ignored outside IDLE; DONE is the only cycle frame_done_out=1.
//  In-window: valid && X_OFFSET<=hcount<X_OFFSET+WIDTH && Y_OFFSET<=vcount<Y_OFFSET+HEIGHT.
//  CAPTURE: each in-window pixel -> one registered write, latency 1 cycle:
//   bram_we_out=1, bram_din_out=(luma_in >= threshold), bram_addr_out=write counter, counter +1.
//   Counter 20 bits, starts 0 at SOF; address never computed by multiply.
//   Write at addr WIDTH*HEIGHT-1 -> DONE next cycle; counter cleared.
//  SOF seen while CAPTURE (dropped pixels): counter restarts at 0 same cycle; frame retaken.
//  SOF pixel itself is processed in same cycle as ARMED->CAPTURE if in-window.
//  Out-of-window or invalid pixels: bram_we_out=0, counter unchanged.
//  Reset mid-capture: abort, IDLE, no further writes; partial BRAM contents undefined.
//  IDLE/ARMED/DONE: bram_we_out=0 always (frozen image for downstream finder).
// CONFIGURATION
//  ADAPTIVE_THRESHOLD_EN defined: during CAPTURE accumulate sum of in-window luma (26-bit);
//   at DONE, next_thresh = min(255, (sum * MEAN_RECIP) >> 24); used at the next arm instead of
//   threshold_in; before the first completed frame, threshold_in is used. Aborted frames discard sum.
//  Not defined: threshold_in latched at arm only; no accumulator logic synthesized.
// STRUCTURE
//  Package qr_capture_pkg: capture_state_t {IDLE, ARMED, CAPTURE, DONE}; FRAME_PIXELS = WIDTH*HEIGHT;
//   MEAN_RECIP = 73 (= round(2^24/230400) for default 480x480).
//  Sub-module luma_mean_accumulator (clear, add-enable, luma, sum, mean), instantiated only under macro.
// TESTING
//  1. Ramp luma=hcount[7:0], threshold 128, req -> after SOF 230400 writes; addr 0..230399 contiguous;
//     din=1 exactly where (hcount)&255 >= 128; frame_done one pulse the cycle after last write.
//  2. Pixels at hcount 399/880, vcount 119/600 -> no write; hcount 400,vcount 120 -> addr 0;
//     hcount 879,vcount 599 -> addr 230399.
//  3. req in IDLE, 2nd req during CAPTURE, SOF mid-frame at addr 1000 -> 2nd req ignored,
//     counter back to 0, exactly 230400 writes after restart.
//  4. rst_in at addr 5000 -> next cycle IDLE, busy 0, we 0; no frame_done; new req captures normally.
//  5. No req for 3 frames -> zero writes; change threshold_in during CAPTURE -> no effect on that frame.
//  6. ADAPTIVE_THRESHOLD_EN, uniform luma 100 frame -> threshold_out 100 (+/-1) on next capture.

Source files
------------

// File: rtl/qr_capture_pkg.sv
// Shared types and default geometry for the camera frame capture/binarize stage.
// Optional feature macro used by the capture top: ADAPTIVE_THRESHOLD_EN.
package qr_capture_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ARMED   = 2'd1,
      CAPTURE = 2'd2,
      DONE    = 2'd3
   } capture_state_t;

   localparam int DEF_WIDTH    = 480;
   localparam int DEF_HEIGHT   = 480;
   localparam int DEF_X_OFFSET = 400;
   localparam int DEF_Y_OFFSET = 120;
   localparam int FRAME_PIXELS = DEF_WIDTH * DEF_HEIGHT;

   // Rounded 2^24/pixels, so that (sum * recip) >> 24 approximates sum / pixels.
   function automatic int mean_recip(input int pixels);
      return ((1 << 24) + pixels / 2) / pixels;
   endfunction

   localparam int MEAN_RECIP = mean_recip(FRAME_PIXELS);

endpackage

// File: rtl/frame_binarizer_capture_if.sv
// Camera pixel stream in, 1-bit frame BRAM write port out.
interface frame_binarizer_capture_if;
   logic        pixel_valid_in;
   logic [10:0] hcount_in;
   logic [9:0]  vcount_in;
   logic [7:0]  luma_in;
   logic [19:0] bram_addr_out;
   logic        bram_din_out;
   logic        bram_we_out;

   modport master (
      output pixel_valid_in, hcount_in, vcount_in, luma_in,
      input  bram_addr_out, bram_din_out, bram_we_out
   );

   modport slave (
      input  pixel_valid_in, hcount_in, vcount_in, luma_in,
      output bram_addr_out, bram_din_out, bram_we_out
   );
endinterface

// File: rtl/luma_mean_accumulator.sv
// Running luma sum over one captured window and its mean via reciprocal multiply.
// Only instantiated when ADAPTIVE_THRESHOLD_EN is defined.
module luma_mean_accumulator
   import qr_capture_pkg::*;
#(
   parameter int RECIP = MEAN_RECIP
) (
   input  logic        clk_in,
   input  logic        rst_in,
   input  logic        clear_in,
   input  logic        add_en_in,
   input  logic [7:0]  luma_in,
   output logic [25:0] sum_out,
   output logic [7:0]  mean_out
);

   logic [25:0] sum_reg;
   logic [63:0] prod;

   // Clear and add in the same cycle starts a fresh sum with the current pixel.
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         sum_reg <= '0;
      end else if (clear_in) begin
         sum_reg <= add_en_in ? 26'(luma_in) : 26'd0;
      end else if (add_en_in) begin
         sum_reg <= sum_reg + 26'(luma_in);
      end
   end

   always_comb begin
      prod = 64'(sum_reg) * 64'(RECIP);
      if (prod >= 64'h0000_0001_0000_0000) begin
         mean_out = 8'hFF;
      end else begin
         mean_out = prod[31:24];
      end
   end

   assign sum_out = sum_reg;

endmodule

// File: rtl/frame_binarizer_capture.sv
// Crops a window from the camera luma stream, thresholds it and writes one frame into the 1-bit BRAM.
// ADAPTIVE_THRESHOLD_EN: next arm uses the mean luma of the last completed frame as threshold.
module frame_binarizer_capture
   import qr_capture_pkg::*;
#(
   parameter int WIDTH    = DEF_WIDTH,
   parameter int HEIGHT   = DEF_HEIGHT,
   parameter int X_OFFSET = DEF_X_OFFSET,
   parameter int Y_OFFSET = DEF_Y_OFFSET
) (
   input  logic                      clk_in,
   input  logic                      rst_in,
   frame_binarizer_capture_if.slave  cam,
   input  logic [7:0]                threshold_in,
   input  logic                      capture_req_in,
   output logic                      busy_out,
   output logic                      frame_done_out,
   output logic [7:0]                threshold_out
);

   localparam int          PIXELS    = WIDTH * HEIGHT;
   localparam logic [10:0] X_LO      = 11'(X_OFFSET);
   localparam logic [10:0] X_HI      = 11'(X_OFFSET + WIDTH);
   localparam logic [9:0]  Y_LO      = 10'(Y_OFFSET);
   localparam logic [9:0]  Y_HI      = 10'(Y_OFFSET + HEIGHT);
   localparam logic [19:0] LAST_ADDR = 20'(PIXELS - 1);

   capture_state_t state_reg;
   logic [19:0]    cnt_reg;
   logic [19:0]    addr_reg;
   logic           din_reg;
   logic           we_reg;
   logic           busy_reg;
   logic           done_reg;
   logic [7:0]     thresh_reg;
   logic [7:0]     arm_thresh;

   logic           sof;
   logic           in_window;
   logic           do_write;
   logic [19:0]    addr_eff;

   // A start-of-frame pixel restarts the write counter in the same cycle it is processed.
   always_comb begin
      sof       = cam.pixel_valid_in && (cam.hcount_in == 11'd0) && (cam.vcount_in == 10'd0);
      in_window = cam.pixel_valid_in
                  && (cam.hcount_in >= X_LO) && (cam.hcount_in < X_HI)
                  && (cam.vcount_in >= Y_LO) && (cam.vcount_in < Y_HI);
      do_write  = in_window && ((state_reg == CAPTURE) || ((state_reg == ARMED) && sof));
      addr_eff  = sof ? 20'd0 : cnt_reg;
   end

`ifdef ADAPTIVE_THRESHOLD_EN
   logic [25:0] acc_sum;
   logic [7:0]  acc_mean;
   logic [7:0]  next_thresh_reg;
   logic        have_next_reg;

   luma_mean_accumulator #(
      .RECIP (mean_recip(PIXELS))
   ) u_acc (
      .clk_in    (clk_in),
      .rst_in    (rst_in),
      .clear_in  (sof),
      .add_en_in (do_write),
      .luma_in   (cam.luma_in),
      .sum_out   (acc_sum),
      .mean_out  (acc_mean)
   );

   // The sum is complete during DONE; an aborted or restarted frame never reaches it.
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         next_thresh_reg <= 8'd0;
         have_next_reg   <= 1'b0;
      end else if (state_reg == DONE) begin
         next_thresh_reg <= acc_mean;
         have_next_reg   <= 1'b1;
      end
   end

   assign arm_thresh = have_next_reg ? next_thresh_reg : threshold_in;
`else
   assign arm_thresh = threshold_in;
`endif

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         state_reg  <= IDLE;
         cnt_reg    <= 20'd0;
         addr_reg   <= 20'd0;
         din_reg    <= 1'b0;
         we_reg     <= 1'b0;
         busy_reg   <= 1'b0;
         done_reg   <= 1'b0;
         thresh_reg <= threshold_in;
      end else begin
         we_reg   <= 1'b0;
         done_reg <= 1'b0;
         case (state_reg)
            IDLE: begin
               if (capture_req_in) begin
                  state_reg  <= ARMED;
                  busy_reg   <= 1'b1;
                  thresh_reg <= arm_thresh;
               end
            end
            ARMED, CAPTURE: begin
               if (sof) begin
                  state_reg <= CAPTURE;
                  cnt_reg   <= 20'd0;
               end
               if (do_write) begin
                  we_reg   <= 1'b1;
                  addr_reg <= addr_eff;
                  din_reg  <= (cam.luma_in >= thresh_reg);
                  if (addr_eff == LAST_ADDR) begin
                     state_reg <= DONE;
                     busy_reg  <= 1'b0;
                     cnt_reg   <= 20'd0;
                  end else begin
                     cnt_reg <= addr_eff + 20'd1;
                  end
               end
            end
            DONE: begin
               state_reg <= IDLE;
               done_reg  <= 1'b1;
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

   assign cam.bram_addr_out = addr_reg;
   assign cam.bram_din_out  = din_reg;
   assign cam.bram_we_out   = we_reg;
   assign busy_out          = busy_reg;
   assign frame_done_out    = done_reg;
   assign threshold_out     = thresh_reg;

endmodule
